// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared constants, state encoding and helpers for the UART packet controller
package uart_pkt_pkg;

   localparam logic [7:0] SYNC_BYTE          = 8'hA5;
   localparam int         MAX_LEN_DEF        = 8;
   localparam int         TIMEOUT_CYCLES_DEF = 50_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OP,
      ST_LEN,
      ST_DATA,
      ST_CHK,
      ST_HOLD
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/uart_pkt_timer.sv
// rtl/uart_pkt_timer.sv - clearable saturating inter-byte timeout counter with one-cycle expiry
module uart_pkt_timer
   import uart_pkt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !enable_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A clear in the same cycle wins, so a byte landing on the last count is not a timeout
   assign expire_o = enable_i && !clear_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_pkt_ctrl.sv
// rtl/uart_pkt_ctrl.sv - UART packet framer/checker (SYNC OP LEN PAYLOAD CHK) with command handshake
// Optional packet counters pkt_ok_cnt/pkt_err_cnt when UART_PKT_STATS_EN is defined.
module uart_pkt_ctrl
   import uart_pkt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int MAX_LEN        = MAX_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   input  logic                 rx_error,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [7:0]           cmd_op,
   output logic [3:0]           cmd_len,
   output logic [8*MAX_LEN-1:0] cmd_payload,
   output logic                 err_chk,
   output logic                 err_len,
   output logic                 err_frame,
   output logic                 err_timeout,
   output logic                 err_overrun,
`ifdef UART_PKT_STATS_EN
   output logic [15:0]          pkt_ok_cnt,
   output logic [15:0]          pkt_err_cnt,
`endif
   output logic                 busy
);

   state_e               state_q, state_d;
   logic [7:0]           op_q, op_d;
   logic [3:0]           len_q, len_d;
   logic [8*MAX_LEN-1:0] pay_q, pay_d;
   logic [3:0]           idx_q, idx_d;
   logic [7:0]           chk_q, chk_d;
   logic                 err_chk_q, err_chk_d;
   logic                 err_len_q, err_len_d;
   logic                 err_frame_q, err_frame_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 err_overrun_q, err_overrun_d;
   logic                 timer_en;
   logic                 timer_expire;

   assign timer_en = (state_q == ST_OP) || (state_q == ST_LEN) ||
                     (state_q == ST_DATA) || (state_q == ST_CHK);

   // Every accepted byte (including the sync that enters OP) restarts the timeout
   uart_pkt_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i    (clk),
      .reset_i  (reset),
      .clear_i  (rx_valid),
      .enable_i (timer_en),
      .expire_o (timer_expire)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      len_d         = len_q;
      pay_d         = pay_q;
      idx_d         = idx_q;
      chk_d         = chk_q;
      err_chk_d     = 1'b0;
      err_len_d     = 1'b0;
      err_frame_d   = 1'b0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d = ST_OP;
               pay_d   = '0;
               idx_d   = '0;
               chk_d   = '0;
            end
         end

         ST_OP, ST_LEN, ST_DATA, ST_CHK: begin
            if (rx_error) begin
               err_frame_d = 1'b1;
               state_d     = ST_IDLE;
            end else if (rx_valid) begin
               case (state_q)
                  ST_OP: begin
                     op_d    = rx_data;
                     chk_d   = chk_q ^ rx_data;
                     state_d = ST_LEN;
                  end
                  ST_LEN: begin
                     chk_d = chk_q ^ rx_data;
                     if (rx_data > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                     end else begin
                        len_d   = rx_data[3:0];
                        state_d = (rx_data == 8'd0) ? ST_CHK : ST_DATA;
                     end
                  end
                  ST_DATA: begin
                     chk_d = chk_q ^ rx_data;
                     for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 4'(i)) begin
                           pay_d[8*i +: 8] = rx_data;
                        end
                     end
                     if (idx_q == len_q - 4'd1) begin
                        state_d = ST_CHK;
                     end else begin
                        idx_d = idx_q + 4'd1;
                     end
                  end
                  ST_CHK: begin
                     if (rx_data == chk_q) begin
                        state_d = ST_HOLD;
                     end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_IDLE;
                     end
                  end
                  default: state_d = state_q;
               endcase
            end else if (timer_expire) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end

         ST_HOLD: begin
            // Bytes arriving while the command is held are dropped, even a sync
            if (rx_valid) begin
               err_overrun_d = 1'b1;
            end
            if (cmd_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         len_q         <= '0;
         pay_q         <= '0;
         idx_q         <= '0;
         chk_q         <= '0;
         err_chk_q     <= 1'b0;
         err_len_q     <= 1'b0;
         err_frame_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         len_q         <= len_d;
         pay_q         <= pay_d;
         idx_q         <= idx_d;
         chk_q         <= chk_d;
         err_chk_q     <= err_chk_d;
         err_len_q     <= err_len_d;
         err_frame_q   <= err_frame_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign cmd_valid   = (state_q == ST_HOLD);
   assign cmd_op      = op_q;
   assign cmd_len     = len_q;
   assign cmd_payload = pay_q;
   assign err_chk     = err_chk_q;
   assign err_len     = err_len_q;
   assign err_frame   = err_frame_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;
   assign busy        = (state_q != ST_IDLE);

`ifdef UART_PKT_STATS_EN
   logic [15:0] ok_cnt_q;
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ok_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         if (cmd_valid && cmd_ready) begin
            ok_cnt_q <= sat_inc16(ok_cnt_q);
         end
         if (err_chk_q || err_len_q || err_frame_q || err_timeout_q || err_overrun_q) begin
            err_cnt_q <= sat_inc16(err_cnt_q);
         end
      end
   end

   assign pkt_ok_cnt  = ok_cnt_q;
   assign pkt_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// tb/tb_uart_pkt_ctrl.sv - self-checking bench for uart_pkt_ctrl: vector table, corner sequences, random packets
module tb_uart_pkt_ctrl;

   localparam int TO = 40;
   localparam int ML = 8;

   localparam int K_NONE  = 0;
   localparam int K_CMD   = 1;
   localparam int K_CHK   = 2;
   localparam int K_LEN   = 3;
   localparam int K_FRAME = 4;
   localparam int K_TO    = 5;
   localparam int K_OVR   = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_error;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [7:0]    cmd_op;
   logic [3:0]    cmd_len;
   logic [8*ML-1:0] cmd_payload;
   logic          err_chk, err_len, err_frame, err_timeout, err_overrun;
   logic          busy;
`ifdef UART_PKT_STATS_EN
   logic [15:0]   pkt_ok_cnt;
   logic [15:0]   pkt_err_cnt;
`endif

   uart_pkt_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_LEN(ML)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_error    (rx_error),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_len     (cmd_len),
      .cmd_payload (cmd_payload),
      .err_chk     (err_chk),
      .err_len     (err_len),
      .err_frame   (err_frame),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
`ifdef UART_PKT_STATS_EN
      .pkt_ok_cnt  (pkt_ok_cnt),
      .pkt_err_cnt (pkt_err_cnt),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;
      logic [7:0] op;
      logic [3:0] len;
      logic [63:0] pay;
   } ev_t;

   typedef struct {
      logic [95:0] b;
      int          n;
      int          k0;
      int          k1;
      logic [7:0]  op;
      logic [3:0]  len;
      logic [63:0] pay;
   } vec_t;

   ev_t  obs_q[$];
   ev_t  exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   function automatic ev_t mk_ev(input int k, input logic [7:0] op, input logic [3:0] len,
                                 input logic [63:0] pay);
      ev_t e;
      e.kind = k;
      e.op   = op;
      e.len  = len;
      e.pay  = pay;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid && cmd_ready) obs_q.push_back(mk_ev(K_CMD, cmd_op, cmd_len, cmd_payload));
         if (err_chk)     obs_q.push_back(mk_ev(K_CHK, 8'h0, 4'h0, 64'h0));
         if (err_len)     obs_q.push_back(mk_ev(K_LEN, 8'h0, 4'h0, 64'h0));
         if (err_frame)   obs_q.push_back(mk_ev(K_FRAME, 8'h0, 4'h0, 64'h0));
         if (err_timeout) obs_q.push_back(mk_ev(K_TO, 8'h0, 4'h0, 64'h0));
         if (err_overrun) obs_q.push_back(mk_ev(K_OVR, 8'h0, 4'h0, 64'h0));
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk);
      #1 rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (gap) @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmp_events(input string tag);
      check({tag, " event count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s ev%0d kind", tag, i), 64'(obs_q[i].kind), 64'(exp_q[i].kind));
         if (exp_q[i].kind == K_CMD && obs_q[i].kind == K_CMD) begin
            check($sformatf("%s ev%0d op", tag, i), 64'(obs_q[i].op), 64'(exp_q[i].op));
            check($sformatf("%s ev%0d len", tag, i), 64'(obs_q[i].len), 64'(exp_q[i].len));
            check($sformatf("%s ev%0d payload", tag, i), obs_q[i].pay, exp_q[i].pay);
         end
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_quiet_outputs(input string tag);
      check({tag, " cmd_valid"}, 64'(cmd_valid), 64'h0);
      check({tag, " cmd_op"}, 64'(cmd_op), 64'h0);
      check({tag, " cmd_len"}, 64'(cmd_len), 64'h0);
      check({tag, " cmd_payload"}, cmd_payload, 64'h0);
      check({tag, " err_*"}, 64'({err_chk, err_len, err_frame, err_timeout, err_overrun}), 64'h0);
      check({tag, " busy"}, 64'(busy), 64'h0);
   endtask

   // Reference: scan the byte stream for framed packets and list the outcome of each one
   function automatic void model(input logic [7:0] s[$]);
      int i;
      int n;
      int ln;
      logic [7:0]  op;
      logic [7:0]  x;
      logic [63:0] pay;
      i = 0;
      n = s.size();
      while (i < n) begin
         if (s[i] != 8'hA5) begin
            i++;
            continue;
         end
         if (i + 2 >= n) break;
         op = s[i+1];
         ln = int'(s[i+2]);
         if (ln > ML) begin
            exp_q.push_back(mk_ev(K_LEN, 8'h0, 4'h0, 64'h0));
            i += 3;
            continue;
         end
         if (i + 3 + ln >= n) break;
         x   = op ^ 8'(ln);
         pay = '0;
         for (int j = 0; j < ln; j++) begin
            pay[8*j +: 8] = s[i+3+j];
            x = x ^ s[i+3+j];
         end
         if (s[i+3+ln] == x) exp_q.push_back(mk_ev(K_CMD, op, 4'(ln), pay));
         else                exp_q.push_back(mk_ev(K_CHK, 8'h0, 4'h0, 64'h0));
         i += 4 + ln;
      end
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       tbl[6];
      logic [7:0] stim[$];
      logic [7:0] b, op, x;
      int         ln, r;

      tbl[0] = '{b:{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65, 48'h0}, n:6, k0:K_CMD, k1:K_NONE,
                 op:8'h10, len:4'd2, pay:64'h4433};
      tbl[1] = '{b:{8'hA5, 8'h20, 8'h00, 8'h20, 64'h0}, n:4, k0:K_CMD, k1:K_NONE,
                 op:8'h20, len:4'd0, pay:64'h0};
      tbl[2] = '{b:{8'hA5, 8'h10, 8'h01, 8'h55, 8'h00, 8'hA5, 8'h10, 8'h01, 8'h55, 8'h44, 16'h0},
                 n:10, k0:K_CHK, k1:K_CMD, op:8'h10, len:4'd1, pay:64'h55};
      tbl[3] = '{b:{8'hA5, 8'h10, 8'h09, 8'hFF, 8'h00, 8'hA5, 8'h01, 8'h00, 8'h01, 24'h0},
                 n:9, k0:K_LEN, k1:K_CMD, op:8'h01, len:4'd0, pay:64'h0};
      tbl[4] = '{b:{8'hA5, 8'h07, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h07},
                 n:12, k0:K_CMD, k1:K_NONE, op:8'h07, len:4'd8, pay:64'h0807060504030201};
      tbl[5] = '{b:{8'hA5, 8'h33, 8'h00, 8'h00, 64'h0}, n:4, k0:K_CHK, k1:K_NONE,
                 op:8'h00, len:4'd0, pay:64'h0};

      reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0; cmd_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_quiet_outputs("reset");
      reset = 1'b0;
      idle(2);
      check_quiet_outputs("after reset");

      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < tbl[t].n; k++) send_byte(tbl[t].b[95-8*k -: 8], 1);
         idle(8);
         exp_q.push_back(mk_ev(tbl[t].k0, tbl[t].op, tbl[t].len, tbl[t].pay));
         if (tbl[t].k1 != K_NONE) exp_q.push_back(mk_ev(tbl[t].k1, tbl[t].op, tbl[t].len, tbl[t].pay));
         cmp_events($sformatf("vec%0d", t));
      end

      // Timeout lands exactly TO cycles after the last accepted byte
      send_byte(8'hA5, 0);
      send_byte(8'h10, 0);
      repeat (TO - 1) @(posedge clk);
      #1 check("timeout busy before expiry", 64'(busy), 64'h1);
      check("timeout pulse early", 64'(err_timeout), 64'h0);
      @(posedge clk);
      #1 check("timeout busy after expiry", 64'(busy), 64'h0);
      check("timeout pulse", 64'(err_timeout), 64'h1);
      idle(TO + 5);
      exp_q.push_back(mk_ev(K_TO, 8'h0, 4'h0, 64'h0));
      cmp_events("timeout");

      // Frame errors: after sync, coincident with a byte, and ignored in IDLE
      send_byte(8'hA5, 0);
      @(posedge clk); #1 rx_error = 1'b1;
      @(posedge clk); #1 rx_error = 1'b0;
      check("frame pulse", 64'(err_frame), 64'h1);
      check("frame busy", 64'(busy), 64'h0);
      send_byte(8'hA5, 1);
      send_byte(8'h10, 1);
      @(posedge clk); #1 rx_error = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
      @(posedge clk); #1 rx_error = 1'b0; rx_valid = 1'b0;
      idle(3);
      @(posedge clk); #1 rx_error = 1'b1;
      @(posedge clk); #1 rx_error = 1'b0;
      check("idle rx_error busy", 64'(busy), 64'h0);
      send_byte(8'hA5, 1); send_byte(8'h10, 1); send_byte(8'h00, 1); send_byte(8'h10, 1);
      idle(5);
      exp_q.push_back(mk_ev(K_FRAME, 8'h0, 4'h0, 64'h0));
      exp_q.push_back(mk_ev(K_FRAME, 8'h0, 4'h0, 64'h0));
      exp_q.push_back(mk_ev(K_CMD, 8'h10, 4'd0, 64'h0));
      cmp_events("frame");

      // Held command with an extra byte: overrun, outputs stable, sync not recovered
      cmd_ready = 1'b0;
      send_byte(8'hA5, 1); send_byte(8'h30, 1); send_byte(8'h01, 1); send_byte(8'h77, 1);
      send_byte(8'h46, 1);
      idle(3);
      check("hold cmd_valid", 64'(cmd_valid), 64'h1);
      send_byte(8'hA5, 0);
      check("overrun pulse", 64'(err_overrun), 64'h1);
      check("hold cmd_valid after overrun", 64'(cmd_valid), 64'h1);
      check("hold cmd_op", 64'(cmd_op), 64'h30);
      check("hold cmd_len", 64'(cmd_len), 64'h1);
      check("hold cmd_payload", cmd_payload, 64'h77);
      idle(3);
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      check("release cmd_valid", 64'(cmd_valid), 64'h0);
      check("release busy", 64'(busy), 64'h0);
      send_byte(8'h30, 1); send_byte(8'h01, 1); send_byte(8'h77, 1); send_byte(8'h46, 1);
      idle(5);
      exp_q.push_back(mk_ev(K_OVR, 8'h0, 4'h0, 64'h0));
      exp_q.push_back(mk_ev(K_CMD, 8'h30, 4'd1, 64'h77));
      cmp_events("overrun");

      // Reset in the middle of a payload discards silently
      send_byte(8'hA5, 1); send_byte(8'h10, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
      send_byte(8'h22, 0);
      check("mid-data busy", 64'(busy), 64'h1);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_quiet_outputs("mid-data reset");
      idle(6);
      check("mid-data reset busy later", 64'(busy), 64'h0);
      cmp_events("mid-data reset");

      // Random packet stream against the stream-level reference
      for (int p = 0; p < 40; p++) begin
         r = int'($urandom_range(0, 9));
         op = 8'($urandom_range(0, 255));
         if (r < 2) begin
            repeat ($urandom_range(1, 3)) begin
               b = 8'($urandom_range(0, 255));
               if (b == 8'hA5) b = 8'h5A;
               stim.push_back(b);
            end
         end else if (r == 2) begin
            stim.push_back(8'hA5);
            stim.push_back(op);
            stim.push_back(8'($urandom_range(ML + 1, 255)));
         end else begin
            ln = int'($urandom_range(0, ML));
            stim.push_back(8'hA5);
            stim.push_back(op);
            stim.push_back(8'(ln));
            x = op ^ 8'(ln);
            for (int j = 0; j < ln; j++) begin
               b = 8'($urandom_range(0, 255));
               stim.push_back(b);
               x = x ^ b;
            end
            if (r < 5) x = x ^ 8'($urandom_range(1, 255));
            stim.push_back(x);
         end
      end
      foreach (stim[k]) send_byte(stim[k], int'($urandom_range(0, 3)));
      idle(10);
      model(stim);
      cmp_events("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
